// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and constants
package fetch_stage_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef logic [ADDR_W-1:0] RomAddress;
    typedef logic [WORD_W-1:0] Word;

    // addi x0,x0,0
    localparam Word NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        RomAddress pc;
        RomAddress next_pc;
        Word       instr;
    } IfIdEntry;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - IF/ID valid/ready record bus between fetch and decode
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic      id_valid;
    logic      id_ready;
    RomAddress id_pc;
    RomAddress id_next_pc;
    Word       id_instr;

    modport master (
        output id_valid, id_pc, id_next_pc, id_instr,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_pc, id_next_pc, id_instr,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry synchronous FIFO of IF/ID records
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enq,
    input  IfIdEntry               enq_data,
    input  logic                   deq,
    output IfIdEntry               head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    IfIdEntry         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !(reset || clear)) mem[wr_ptr] <= enq_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: ROM issue with credit control, response queue, flush
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int  DEPTH     = 2,
    parameter Word NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
    parameter int  CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  RomAddress        pc,
    input  RomAddress        pc_plus4,
    output logic             pc_advance,
    output RomAddress        rom_addr,
    output logic             rom_en,
    input  Word              rom_data,
    input  logic             flush,
    fetch_stage_if.master    id,
    output logic [CNT_W-1:0] bubble_count
);
    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int CRW = $clog2(DEPTH) + 2;

    logic [QCW-1:0] q_count;
    IfIdEntry       head;
    IfIdEntry       resp;
    logic           inflight;
    RomAddress      req_pc;
    RomAddress      req_next_pc;
    logic           head_valid;
    logic           deq;
    logic           enq;
    logic [CRW-1:0] credit_used;

    assign head_valid = !reset && (q_count != '0);
    assign deq        = head_valid && id.id_ready && !flush;
    assign enq        = inflight && !flush && !reset;

    // A fetch is issued only if its response is guaranteed a queue slot next cycle
    assign credit_used = CRW'(q_count) + CRW'(inflight) - CRW'(deq);
    assign pc_advance  = !reset && !flush && (credit_used < CRW'(DEPTH));
    assign rom_addr    = pc;
    assign rom_en      = pc_advance;

    assign resp = '{pc: req_pc, next_pc: req_next_pc, instr: rom_data};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .enq      (enq),
        .enq_data (resp),
        .deq      (deq),
        .head     (head),
        .count    (q_count)
    );

    // No issue happens under flush, so the in-flight bit drops and the stale response is ignored
    always_ff @(posedge clk) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= pc_advance;
    end

    always_ff @(posedge clk) begin
        if (pc_advance) begin
            req_pc      <= pc;
            req_next_pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (id.id_ready && !head_valid && !(&bubble_count)) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    assign id.id_valid   = head_valid;
    assign id.id_pc      = head_valid ? head.pc      : '0;
    assign id.id_next_pc = head_valid ? head.next_pc : '0;
    assign id.id_instr   = head_valid ? head.instr   : NOP_INSTR;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic      ready;
        logic      flush;
        RomAddress target;
        logic      exp_adv;
        logic      exp_valid;
        RomAddress exp_pc;
        int        exp_bubble;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush;
    RomAddress   target;
    RomAddress   pc1, pc_plus4_1, rom_addr1;
    logic        adv1, rom_en1;
    Word         rom_data1;
    logic [31:0] bubble1;

    logic        reset2, flush2;
    RomAddress   pc2, pc_plus4_2, rom_addr2;
    logic        adv2, rom_en2;
    Word         rom_data2;
    logic [2:0]  bubble2;

    fetch_stage_if id1();
    fetch_stage_if id2();

    int checks = 0;
    int errors = 0;

    RomAddress exp_pc;
    int        exp_bubble;
    int        starve;
    bit        prev_flush;
    int        exp_b2;
    vec_t      tbl [21];

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .pc(pc1), .pc_plus4(pc_plus4_1),
        .pc_advance(adv1), .rom_addr(rom_addr1), .rom_en(rom_en1),
        .rom_data(rom_data1), .flush(flush), .id(id1), .bubble_count(bubble1)
    );

    fetch_stage #(.DEPTH(DEPTH), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset2), .pc(pc2), .pc_plus4(pc_plus4_2),
        .pc_advance(adv2), .rom_addr(rom_addr2), .rom_en(rom_en2),
        .rom_data(rom_data2), .flush(flush2), .id(id2), .bubble_count(bubble2)
    );

    function automatic Word rom_word(input RomAddress a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // PC register and synchronous ROM around each DUT
    assign pc_plus4_1 = pc1 + 32'd4;
    assign pc_plus4_2 = pc2 + 32'd4;

    always @(posedge clk) begin
        if (reset)      pc1 <= '0;
        else if (flush) pc1 <= target;
        else if (adv1)  pc1 <= pc1 + 32'd4;
        if (rom_en1) rom_data1 <= rom_word(rom_addr1);
    end

    always @(posedge clk) begin
        if (reset2)      pc2 <= '0;
        else if (flush2) pc2 <= 32'h80;
        else if (adv2)   pc2 <= pc2 + 32'd4;
        if (rom_en2) rom_data2 <= rom_word(rom_addr2);
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_vec(input int k, input logic r, input logic f, input logic [31:0] tgt,
                           input logic a, input logic v, input logic [31:0] p, input int b);
        tbl[k] = '{r, f, tgt, a, v, p, b};
    endtask

    // Scoreboard: the delivered stream must be the architectural PC sequence
    task automatic monitor1();
        check_eq("q_count_le_depth", {31'd0, dut.q_count <= DEPTH}, 32'd1);
        check_eq("bubble_count", bubble1, exp_bubble);
        if (reset) begin
            check_eq("rst_adv", {31'd0, adv1}, 32'd0);
            check_eq("rst_valid", {31'd0, id1.id_valid}, 32'd0);
            check_eq("rst_instr", id1.id_instr, NOP_INSTR);
            check_eq("rst_pc", id1.id_pc, 32'd0);
            check_eq("rst_next_pc", id1.id_next_pc, 32'd0);
        end else begin
            if (!id1.id_valid) check_eq("idle_instr", id1.id_instr, NOP_INSTR);
            if (prev_flush) check_eq("flush_kill", {31'd0, id1.id_valid}, 32'd0);
            if (id1.id_valid && id1.id_ready && !flush) begin
                check_eq("stream_pc", id1.id_pc, exp_pc);
                check_eq("stream_next_pc", id1.id_next_pc, exp_pc + 32'd4);
                check_eq("stream_instr", id1.id_instr, rom_word(exp_pc));
            end
            if (!flush && id1.id_ready && !id1.id_valid) begin
                starve++;
                check_eq("starve_le_2", {31'd0, starve <= 2}, 32'd1);
            end else begin
                starve = 0;
            end
        end
        prev_flush = flush && !reset;
        if (reset) begin
            exp_pc = '0;
            exp_bubble = 0;
            starve = 0;
        end else begin
            if (id1.id_ready && !id1.id_valid) exp_bubble++;
            if (flush) exp_pc = target;
            else if (id1.id_valid && id1.id_ready) exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic step1();
        @(negedge clk);
        monitor1();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            id1.id_ready = tbl[k].ready;
            flush = tbl[k].flush;
            target = tbl[k].target;
            @(negedge clk);
            check_eq($sformatf("row%0d_adv", k), {31'd0, adv1}, {31'd0, tbl[k].exp_adv});
            check_eq($sformatf("row%0d_valid", k), {31'd0, id1.id_valid}, {31'd0, tbl[k].exp_valid});
            if (tbl[k].exp_valid) begin
                check_eq($sformatf("row%0d_pc", k), id1.id_pc, tbl[k].exp_pc);
                check_eq($sformatf("row%0d_next_pc", k), id1.id_next_pc, tbl[k].exp_pc + 32'd4);
                check_eq($sformatf("row%0d_instr", k), id1.id_instr, rom_word(tbl[k].exp_pc));
            end else begin
                check_eq($sformatf("row%0d_nop", k), id1.id_instr, NOP_INSTR);
            end
            check_eq($sformatf("row%0d_bubble", k), bubble1, tbl[k].exp_bubble);
            if (k == 11) check_eq("stall_count_full", {30'd0, dut.q_count}, 32'd2);
            monitor1();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step2();
        @(negedge clk);
        check_eq("sat_bubble", {29'd0, bubble2}, exp_b2);
        if (reset2) exp_b2 = 0;
        else if (id2.id_ready && !id2.id_valid && exp_b2 < 7) exp_b2++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // cycle-by-cycle expectations after reset release, pc starting at 0
        set_vec(0,  1, 0, 0,     1, 0, 32'h00, 0);
        set_vec(1,  1, 0, 0,     1, 0, 32'h00, 1);
        for (int k = 2; k <= 9; k++) set_vec(k, 1, 0, 0, 1, 1, 32'(4 * (k - 2)), 2);
        for (int k = 10; k <= 13; k++) set_vec(k, 0, 0, 0, 0, 1, 32'h20, 2);
        set_vec(14, 1, 0, 0,     1, 1, 32'h20, 2);
        set_vec(15, 1, 0, 0,     1, 1, 32'h24, 2);
        set_vec(16, 1, 1, 32'h40, 0, 1, 32'h28, 2);
        set_vec(17, 1, 0, 0,     1, 0, 32'h00, 2);
        set_vec(18, 1, 0, 0,     1, 0, 32'h00, 3);
        set_vec(19, 1, 0, 0,     1, 1, 32'h40, 4);
        set_vec(20, 1, 0, 0,     1, 1, 32'h44, 4);

        exp_pc = '0;
        exp_bubble = 0;
        starve = 0;
        prev_flush = 1'b0;
        exp_b2 = 0;
        reset = 1'b1;
        flush = 1'b0;
        target = '0;
        id1.id_ready = 1'b1;
        reset2 = 1'b1;
        flush2 = 1'b0;
        id2.id_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step1();
        reset = 1'b0;
        apply_rows(0, 20);

        for (int i = 0; i < 20; i++) begin
            id1.id_ready = (i % 2 == 0);
            flush = 1'b0;
            step1();
        end

        for (int i = 0; i < 1500; i++) begin
            id1.id_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            target = RomAddress'($urandom_range(0, 1023)) << 2;
            step1();
        end

        // reset and flush together: reset must win
        id1.id_ready = 1'b1;
        reset = 1'b1;
        flush = 1'b1;
        target = 32'h200;
        step1();
        flush = 1'b0;
        step1();
        step1();
        reset = 1'b0;
        apply_rows(0, 9);
        reset = 1'b1;

        // saturating bubble counter on the narrow instance
        step2();
        reset2 = 1'b0;
        for (int i = 0; i < 6; i++) step2();
        id2.id_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            flush2 = (i % 2 == 0);
            step2();
        end
        @(negedge clk);
        check_eq("sat_final", {29'd0, bubble2}, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
